// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - shared encodings for the multicycle controller
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Map the data-processing cmd field onto the ALU operation; unknown cmds add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition evaluation and NZCV flags register
module cond_unit
  import mc_controller_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_alu_op,
  input  logic       i_set_flags,
  input  logic       i_update_cv,
  input  logic       i_use_saved,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;
  logic       r_cond_saved;
  logic       w_cond_raw;
  logic       w_cond_live;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluate the instruction condition against the current flags register.
  always_comb begin
    w_cond_raw = 1'b0;
    case (i_cond)
      COND_EQ: w_cond_raw = w_z;
      COND_NE: w_cond_raw = ~w_z;
      COND_CS: w_cond_raw = w_c;
      COND_CC: w_cond_raw = ~w_c;
      COND_MI: w_cond_raw = w_n;
      COND_PL: w_cond_raw = ~w_n;
      COND_VS: w_cond_raw = w_v;
      COND_VC: w_cond_raw = ~w_v;
      COND_HI: w_cond_raw = w_c & ~w_z;
      COND_LS: w_cond_raw = ~w_c | w_z;
      COND_GE: w_cond_raw = (w_n == w_v);
      COND_LT: w_cond_raw = (w_n != w_v);
      COND_GT: w_cond_raw = ~w_z & (w_n == w_v);
      COND_LE: w_cond_raw = w_z | (w_n != w_v);
      COND_AL: w_cond_raw = 1'b1;
      default: w_cond_raw = 1'b0;
    endcase
  end

  assign w_cond_live = COND_EN ? w_cond_raw : 1'b1;

  // The write-back cycle must see the verdict taken before this instruction
  // rewrote the flags, so the execute-cycle verdict is held for it.
  assign o_cond_ex = i_use_saved ? r_cond_saved : w_cond_live;

  // Flags update at the end of an ALU cycle; logical ops leave C and V alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flags      <= 4'b0000;
      r_cond_saved <= 1'b0;
    end else if (i_alu_op) begin
      r_cond_saved <= w_cond_live;
      if (i_set_flags && w_cond_live) begin
        r_flags[3:2] <= i_alu_flags[3:2];
        if (i_update_cv) begin
          r_flags[1:0] <= i_alu_flags[1:0];
        end
      end
    end
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle processor control FSM
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  state_t     r_state;
  state_t     w_next;
  logic       w_alu_op;
  logic [1:0] w_alu_ctrl;
  logic       w_cond_ex;
  logic       w_rd_pc;

  assign w_alu_op   = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
  assign w_alu_ctrl = alu_decode(Funct[4:1]);
  assign w_rd_pc    = (Rd == 4'd15);
  assign State      = r_state;
  assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
  assign ImmSrc     = Op;
  assign ALUControl = w_alu_op ? w_alu_ctrl : ALU_ADD;

  cond_unit #(
    .COND_EN(COND_EN)
  ) u_cond (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_cond     (Cond),
    .i_alu_flags(ALUFlags),
    .i_alu_op   (w_alu_op),
    .i_set_flags(Funct[0]),
    .i_update_cv((w_alu_ctrl == ALU_ADD) || (w_alu_ctrl == ALU_SUB)),
    .i_use_saved(r_state == S_ALUWB),
    .o_cond_ex  (w_cond_ex)
  );

  // State register; reset abandons any in-flight instruction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobe decode.
  always_comb begin
    w_next    = S_FETCH;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_WD;
    ResultSrc = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_next    = S_DECODE;
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        w_next = S_MEMWB;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = w_cond_ex;
        PCWrite   = w_cond_ex & w_rd_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = w_cond_ex;
      end
      S_EXECUTER: begin
        w_next  = S_ALUWB;
        ALUSrcB = SRCB_WD;
      end
      S_EXECUTEI: begin
        w_next  = S_ALUWB;
        ALUSrcB = SRCB_IMM;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = w_cond_ex;
        PCWrite   = w_cond_ex & w_rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = w_cond_ex;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl;
  logic [3:0] State;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model flags, current phase and per-instruction observations
  logic   m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  state_t cur_phase = S_FETCH;
  logic   cur_ok = 1'b0;
  logic   checking = 1'b0;
  int     n_cyc, n_regw, n_memw, regw_cyc, memw_cyc;
  logic   br_pcw;
  logic [1:0] wb_rw_pc;

  wire [19:0] dut_vec = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                         ALUSrcA, RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic cond_holds(input logic [3:0] c);
    case (c)
      4'd0:  return m_z;
      4'd1:  return !m_z;
      4'd2:  return m_c;
      4'd3:  return !m_c;
      4'd4:  return m_n;
      4'd5:  return !m_n;
      4'd6:  return m_v;
      4'd7:  return !m_v;
      4'd8:  return m_c && !m_z;
      4'd9:  return !m_c || m_z;
      4'd10: return m_n == m_v;
      4'd11: return m_n != m_v;
      4'd12: return !m_z && (m_n == m_v);
      4'd13: return m_z || (m_n != m_v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word for one phase, straight from the state output table.
  function automatic logic [19:0] exp_out(input state_t p, input logic ok,
                                          input logic [1:0] op, input logic [5:0] fn,
                                          input logic [3:0] rd);
    logic pcw, mw, rw, irw, adr, srca;
    logic [1:0] srcb, res, aluc;
    pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; srca = 0;
    srcb = 2'b00; res = 2'b00; aluc = 2'b00;
    case (p)
      S_FETCH:  begin irw = 1; srca = 1; srcb = 2'b10; res = 2'b10; pcw = 1; end
      S_DECODE: begin srca = 1; srcb = 2'b10; res = 2'b10; end
      S_MEMADR: srcb = 2'b01;
      S_MEMRD:  adr = 1;
      S_MEMWB:  begin res = 2'b01; rw = ok; pcw = ok && rd == 4'd15; end
      S_MEMWR:  begin adr = 1; mw = ok; end
      S_EXECUTER, S_EXECUTEI: begin
        srcb = (p == S_EXECUTEI) ? 2'b01 : 2'b00;
        case (fn[4:1])
          4'b0010: aluc = 2'b01;
          4'b0000: aluc = 2'b10;
          4'b1100: aluc = 2'b11;
          default: aluc = 2'b00;
        endcase
      end
      S_ALUWB:  begin rw = ok; pcw = ok && rd == 4'd15; end
      S_BRANCH: begin srcb = 2'b01; res = 2'b10; pcw = ok; end
      default: ;
    endcase
    return {4'(p), pcw, mw, rw, irw, adr, srca, op == 2'b01, op == 2'b10, op,
            srcb, res, aluc};
  endfunction

  // Per-cycle comparison of the whole control word against the model.
  always @(negedge clk) begin
    if (checking) begin
      n_cyc++;
      check($sformatf("cyc%0d_%s", n_cyc, cur_phase.name()), 32'(dut_vec),
            32'(exp_out(cur_phase, cur_ok, Op, Funct, Rd)));
      if (RegWrite) begin n_regw++; regw_cyc = n_cyc; end
      if (MemWrite) begin n_memw++; memw_cyc = n_cyc; end
      if (cur_phase == S_BRANCH) br_pcw = PCWrite;
      if (cur_phase == S_ALUWB) wb_rw_pc = {RegWrite, PCWrite};
    end
  end

  // Runs one instruction through the model; abort_memwr pulses reset on entering MEMWR.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] fl, input bit abort_memwr);
    state_t path[$];
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = fl;
    cur_ok = cond_holds(c);
    n_cyc = 0; n_regw = 0; n_memw = 0; regw_cyc = 0; memw_cyc = 0;
    br_pcw = 1'bx; wb_rw_pc = 2'bxx;
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (op)
      2'b01: begin
        path.push_back(S_MEMADR);
        if (fn[0]) begin path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
        else path.push_back(S_MEMWR);
      end
      2'b00: begin
        path.push_back(fn[5] ? S_EXECUTEI : S_EXECUTER);
        path.push_back(S_ALUWB);
      end
      2'b10: path.push_back(S_BRANCH);
      default: ;
    endcase
    foreach (path[i]) begin
      cur_phase = path[i];
      if (abort_memwr && path[i] == S_MEMWR) begin
        checking = 1'b0;
        check("memwr_before_rst", 32'(MemWrite), 32'(cur_ok));
        reset = 1'b1;
        #1;
        check("rst_memwrite_drop", 32'(MemWrite), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_state_now", 32'(State), 32'(S_FETCH));
        @(posedge clk);
        #1;
        check("rst_held_state", 32'(State), 32'(S_FETCH));
        check("rst_held_irwrite", 32'(IRWrite), 32'd1);
        reset = 1'b0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        checking = 1'b1;
        return;
      end
      checking = 1'b1;
      @(posedge clk);
      if ((path[i] == S_EXECUTER || path[i] == S_EXECUTEI) && fn[0] && cur_ok) begin
        {m_n, m_z} = fl[3:2];
        if (fn[4:1] != 4'b0000 && fn[4:1] != 4'b1100) {m_c, m_v} = fl[1:0];
      end
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(State), 32'(S_FETCH));
    check("reset_irwrite", 32'(IRWrite), 32'd1);
    check("reset_pcwrite", 32'(PCWrite), 32'd1);
    check("reset_regwrite", 32'(RegWrite), 32'd0);
    reset = 1'b0;

    // LDR
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'd0, 0);
    check("ldr_cycles", 32'(n_cyc), 32'd5);
    check("ldr_regw_count", 32'(n_regw), 32'd1);
    check("ldr_regw_cycle", 32'(regw_cyc), 32'd5);
    // STR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'd0, 0);
    check("str_memw_count", 32'(n_memw), 32'd1);
    check("str_memw_cycle", 32'(memw_cyc), 32'd4);
    check("str_regw_count", 32'(n_regw), 32'd0);
    // SUBS Z=1 then BEQ taken
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("beq_taken", 32'(br_pcw), 32'd1);
    // SUBS Z=0 then BEQ not taken
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("beq_not_taken", 32'(br_pcw), 32'd0);
    // ADD to PC
    run_instr(4'hE, 2'b00, 6'b101000, 4'd15, 4'd0, 0);
    check("add_pc_rw_pcw", 32'(wb_rw_pc), 32'b11);
    // never-condition ADDS must not write nor touch flags
    run_instr(4'hF, 2'b00, 6'b101001, 4'd2, 4'b0100, 0);
    check("nv_regw_count", 32'(n_regw), 32'd0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("nv_flags_kept", 32'(br_pcw), 32'd0);
    // EQ SUBS clearing Z still writes back (old flags decide)
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0);
    run_instr(4'h0, 2'b00, 6'b000101, 4'd4, 4'b0000, 0);
    check("eq_self_update_regw", 32'(n_regw), 32'd1);
    // ANDS keeps C; ADDS sets it
    run_instr(4'hE, 2'b00, 6'b000001, 4'd1, 4'b0010, 0);
    run_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("ands_keeps_c", 32'(br_pcw), 32'd0);
    run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0010, 0);
    run_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("adds_sets_c", 32'(br_pcw), 32'd1);
    // ORRS with N=1, then LT/GE/MI
    run_instr(4'hE, 2'b00, 6'b011001, 4'd5, 4'b1000, 0);
    run_instr(4'hB, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    run_instr(4'hA, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    // undefined op class
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0, 0);
    check("op11_cycles", 32'(n_cyc), 32'd2);
    // reset mid-store after setting Z
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0);
    run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'd0, 1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("rst_flags_cleared_beq", 32'(br_pcw), 32'd0);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'd0, 0);
    check("rst_flags_cleared_bne", 32'(br_pcw), 32'd1);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter COND_EN, default 1; when 0, every instruction executes as AL (condition check bypassed).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Cond, input, 4, Instr[31:28].
REQ-005 SHALL have port Op, input, 2, Instr[27:26].
REQ-006 SHALL have port Funct, input, 6, Instr[25:20].
REQ-007 SHALL have port Rd, input, 4, Instr[15:12].
REQ-008 SHALL have port ALUFlags, input, 4, {N,Z,C,V} from the ALU.
REQ-009 SHALL have ports PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc and ALUSrcA, output, 1 each; AdrSrc 0=PC, 1=Result; ALUSrcA 0=register A, 1=PC.
REQ-010 SHALL have ports RegSrc, ImmSrc, ALUSrcB, ResultSrc and ALUControl, output, 2 each; ALUSrcB 00=WriteData, 01=ExtImm, 10=const 4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult.
REQ-011 SHALL have port State, output, 4, current FSM state for debug.

Function
REQ-012 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH; all outputs SHALL be decoded from the registered state plus registered flags, with no input-to-strobe path except CondEx and Rd.
REQ-013 SHALL transition FETCH->DECODE unconditionally.
REQ-014 SHALL transition from DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER; Op=00 with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH with no write strobes.
REQ-015 SHALL transition MEMADR->MEMRD if Funct[0]=1, else MEMWR; MEMRD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWR, ALUWB and BRANCH->FETCH.
REQ-016 SHALL drive these per-state outputs (unlisted outputs 0): FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1, AdrSrc=0.
REQ-017 Per-state outputs continued: DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. MEMADR: ALUSrcB=01. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=CondEx. MEMWR: AdrSrc=1, MemWrite=CondEx.
REQ-018 Per-state outputs continued: EXECUTER: ALUSrcB=00, ALUOp. EXECUTEI: ALUSrcB=01, ALUOp. ALUWB: ResultSrc=00, RegWrite=CondEx. BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
REQ-019 SHALL assert PCWrite in MEMWB and ALUWB when Rd=15 and CondEx=1.
REQ-020 SHALL drive ALUControl=00 (ADD) outside ALUOp states; in ALUOp states, Funct[4:1] SHALL map 0100->00, 0010->01 (SUB), 0000->10 (AND), 1100->11 (ORR), any other->00.
REQ-021 SHALL drive RegSrc[0]=(Op==10), RegSrc[1]=(Op==01) and ImmSrc=Op in every state.
REQ-022 SHALL compute CondEx from Cond and the flags register: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, and 1111->0.
REQ-023 SHALL load flags[3:2] (N,Z) from ALUFlags at the clock edge ending an ALUOp state when Funct[0]=1 and CondEx=1.
REQ-024 SHALL load flags[1:0] (C,V) under the REQ-023 condition only when ALUControl is 00 or 01.
REQ-025 Flags SHALL be unchanged in all other cycles; the condition evaluated in ALUWB SHALL use the flags register as it was before the instruction's own update.

Reset
REQ-026 Asserting reset SHALL immediately force state=FETCH and flags=0000 regardless of clk; an in-flight instruction SHALL be abandoned with no further MemWrite or RegWrite.
REQ-027 While reset is held, outputs SHALL equal the FETCH decode; the first rising edge after deassertion SHALL move to DECODE.

Structure
REQ-028 A shared package SHALL hold the state enumeration, condition-code constants, Op constants and the ALUControl, ALUSrcB and ResultSrc encodings.
REQ-029 Condition evaluation and the flags register SHALL live in one sub-module, cond_unit.

Verification
REQ-030 LDR, Op=01, Funct=011001, Cond=1110: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 only in MEMWB; 5 cycles.
REQ-031 STR, Funct[0]=0: MEMWR reached in cycle 4, MemWrite=1 for exactly 1 cycle, RegWrite never asserted.
REQ-032 SUBS with Funct=000101 and ALUFlags=0100 in EXECUTER, then BEQ (Cond=0000, Op=10): branch PCWrite=1 in BRANCH; repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
REQ-033 ADD with Rd=15, Cond=1110: ALUWB asserts both RegWrite=1 and PCWrite=1.
REQ-034 Cond=1111 data-processing: RegWrite=0 and flags unchanged.
REQ-035 Reset pulsed mid-MEMWR: MemWrite drops the same cycle, State=FETCH, flags=0000.
